// File: rtl/deserialize.sv
// deserialize
//   Receive-side counterpart of the ciphertext serializer. Samples an
//   MSB-first serial stream framed by a high-active flag, rebuilds the
//   MSG_SIZE-bit word, checks the frame length and hands the word
//   downstream through a hold-until-read valid handshake.
//
// Ports
//   iClk          clock, rising edge
//   iRst          synchronous active-high reset
//   iEn           sampling enable; low freezes all frame state
//   iSerial_in    serial data bit, MSB first
//   iSerial_flag  frame flag, high for MSG_SIZE sampled cycles per frame
//   iRead         downstream consumes oMessage (acts even when iEn=0)
//   oMessage      last committed word
//   oValid        oMessage holds an unread word
//   oBit_counter  index of the next bit expected in the current frame
//   oBusy         receiver not idle
//   oFrame_error  one-cycle pulse on a short or overlong frame
//   oOverrun      one-cycle pulse when an unread word is overwritten
module deserialize #(
  parameter int MSG_SIZE = 64
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iEn,
  input  logic                        iSerial_in,
  input  logic                        iSerial_flag,
  input  logic                        iRead,
  output logic [MSG_SIZE-1:0]         oMessage,
  output logic                        oValid,
  output logic [$clog2(MSG_SIZE)-1:0] oBit_counter,
  output logic                        oBusy,
  output logic                        oFrame_error,
  output logic                        oOverrun
);

  localparam int CW = $clog2(MSG_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [MSG_SIZE-1:0] r_sr;
  logic [MSG_SIZE-1:0] w_sr_nxt;
  logic [MSG_SIZE-1:0] r_msg;
  logic                r_valid;
  logic                r_ferr;
  logic                r_ovr;
  logic                w_commit;
  logic                w_ferr;
  logic                w_last;

  assign w_last = (r_cnt == CW'(MSG_SIZE - 1));

  // Next-state / datapath decode. Nothing advances unless iEn is high, so a
  // stall leaves state, counter and shift register exactly where they were.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
    if (iEn) begin
      case (r_state)
        IDLE: begin
          if (iSerial_flag) begin
            // First bit lands at the bottom; MSG_SIZE-1 further shifts carry
            // it up to the MSB position.
            w_sr_nxt    = {{(MSG_SIZE-1){1'b0}}, iSerial_in};
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (iSerial_flag) begin
            w_sr_nxt = {r_sr[MSG_SIZE-2:0], iSerial_in};
            if (w_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = TRAIL;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            // Flag dropped early: short frame, drop the partial word.
            w_ferr      = 1'b1;
            w_sr_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        TRAIL: begin
          if (iSerial_flag) begin
            // Flag still high after the last bit: overlong frame.
            w_ferr      = 1'b1;
            w_state_nxt = DRAIN;
          end else begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        DRAIN: begin
          // Wait for the flag to fall before a new frame may start.
          if (!iSerial_flag) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_msg   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      r_ferr  <= w_ferr;
      // A commit that coincides with a read replaces a consumed word, so it
      // is not an overrun.
      r_ovr   <= w_commit & r_valid & ~iRead;
      if (w_commit) begin
        r_msg   <= r_sr;
        r_valid <= 1'b1;
      end else if (iRead) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign oMessage     = r_msg;
  assign oValid       = r_valid;
  assign oBit_counter = r_cnt;
  assign oBusy        = (r_state != IDLE);
  assign oFrame_error = r_ferr;
  assign oOverrun     = r_ovr;

endmodule

// File: doc/deserialize.md
# deserialize

Receive-side counterpart of the ciphertext serializer. It samples an MSB-first serial bit stream that is framed by a high-active flag and rebuilds the `MSG_SIZE`-bit word. It checks the frame length and presents the word through a hold-until-read valid handshake to the downstream decrypt/compare logic. It sits at the far end of the serial link, directly fed by the serializer's `oSerial_out` / `oSerial_flag`.

## Interface
Parameters:
- `MSG_SIZE`, default 64: message width in bits. Must be a power of two, ≥ 4.

Ports:
- `iClk`, input, 1: clock. Single clock domain; all logic on the rising edge.
- `iRst`, input, 1: synchronous, active-high reset.
- `iEn`, input, 1: sampling enable. Low stalls all frame state.
- `iSerial_in`, input, 1: serial data bit, MSB first.
- `iSerial_flag`, input, 1: frame flag. High for exactly `MSG_SIZE` sampled cycles per frame.
- `iRead`, input, 1: downstream consumes `oMessage`. Honoured regardless of `iEn`.
- `oMessage`, output, `MSG_SIZE`: last committed word.
- `oValid`, output, 1: `oMessage` holds an unread word.
- `oBit_counter`, output, `$clog2(MSG_SIZE)`: index of the next bit expected in the current frame.
- `oBusy`, output, 1: state ≠ IDLE.
- `oFrame_error`, output, 1: one-cycle pulse on a short or overlong frame.
- `oOverrun`, output, 1: one-cycle pulse when an unread word is overwritten.

## Operation
**Sampling.** A sample is an edge with `iRst`=0 and `iEn`=1. With `iEn`=0:
- state, counter and shift register hold;
- no error or overrun pulses are generated;
- only the `iRead` clearing of `oValid` still acts.

**States:**
- **IDLE**
  - Flag=1: shift `iSerial_in` in as bit `MSG_SIZE-1`, counter←1, go to SHIFT.
  - Flag=0: stay.
- **SHIFT**
  - Flag=1: shift register ← {sr[MSG_SIZE-2:0], `iSerial_in`}, counter+1.
  - Flag=1 while receiving bit index `MSG_SIZE-1`: counter←0, go to TRAIL.
  - Flag=0 (short frame): pulse `oFrame_error`, clear the shift register, counter←0, go to IDLE. `oMessage` and `oValid` are untouched.
- **TRAIL** (one sample after the last bit)
  - Flag=0: commit the shift register to `oMessage`, `oValid`←1, go to IDLE.
  - Flag=1 (overlong frame): pulse `oFrame_error`, discard the word, go to DRAIN.
- **DRAIN**
  - Ignore data until a sample with flag=0, then go to IDLE.
  - No new frame can start until the flag has been seen low.

**Handshake:**
- `oValid` rises on commit and stays high until an edge with `iRead`=1. `oMessage` is stable while `oValid`=1.
- `iRead` with `oValid`=0 has no effect.
- Commit while `oValid`=1 and `iRead`=0:
  - `oMessage` takes the new word;
  - `oValid` stays 1;
  - `oOverrun` pulses.
- Commit and `iRead` on the same edge: `oMessage` takes the new word, `oValid` stays 1, no overrun.

**Reset.** State IDLE; counter 0; shift register 0. Output reset values: `oMessage`=0, `oValid`=0, `oBit_counter`=0, `oBusy`=0, `oFrame_error`=0, `oOverrun`=0.

## Timing
- Frame bits sampled on samples k=0..`MSG_SIZE`-1; trailing flag-low sampled on sample `MSG_SIZE`.
- `oMessage`/`oValid` are registered and visible after sample `MSG_SIZE`. Latency from the edge sampling the first bit is `MSG_SIZE`+1 clock edges when `iEn` is continuously high.
- `oFrame_error` is registered and asserted for the clock cycle after the offending sample:
  - short frame: the first flag-low sample in SHIFT;
  - overlong frame: the flag-high sample in TRAIL.
- `oOverrun` is registered and asserted in the same cycle that `oValid`/`oMessage` update on the overwriting commit.
- `oBit_counter` and `oBusy` are registered and reflect state after each edge.
- Back-to-back frames are legal: a flag-low gap of exactly one sample is the minimum (TRAIL→IDLE); the next flag-high sample starts a new frame.
- Reset mid-frame discards the partial word. If the flag is still high after reset release, the remainder is received as a new, short frame. It then ends with `oFrame_error` if the flag drops.

## Test plan
- **Nominal frame.** Setup: `MSG_SIZE`=64, `iEn`=1, drive 64'hDEADBEEFCAFEF00D MSB-first with the flag high for 64 cycles, then low. Required: `oValid`=1 and `oMessage`=64'hDEADBEEFCAFEF00D after the 65th edge; `oBusy` high during cycles 1–64; no error. Then `iRead`=1 for one cycle → `oValid`=0.
- **Stall.** Same frame with `iEn` low for 3 cycles after bit 10, holding data and flag. Required: `oBit_counter` holds 11 during the stall; identical word committed, 3 cycles later than nominal.
- **Short frame.** Flag high for 40 bits, then low. Required: one-cycle `oFrame_error`, `oValid` stays 0, IDLE with counter 0. A following valid frame 64'h0123456789ABCDEF is received correctly.
- **Overlong frame.** Flag high for 66 cycles. Required: one `oFrame_error` pulse after the 65th sample; no commit; `oBusy` drops only after the flag goes low.
- **Overrun and same-edge read.** Two back-to-back frames A=64'h1 and B=64'h2 with `iRead`=0. Required: after B, `oMessage`=2, `oValid`=1, `oOverrun` pulses once. Repeat with `iRead`=1 on B's commit edge: no overrun, `oValid`=1.
- **Mid-frame reset.** Reset 1 cycle at bit 20, flag held high through bit 63, then low. Required: all outputs 0 on the cycle after reset; then `oFrame_error` pulses once the flag drops (43-bit short frame); `oValid` stays 0. Also run the nominal case at `MSG_SIZE`=8 with 8'hA5.
